// File: rtl/ufib_pkg.sv
// rtl/ufib_pkg.sv - UFI bus fabric command-word field layout and helpers
//
// Command word layout, counted down from the MSB of an A-bit word:
//   bit A-1            REQ  (request valid / return valid)
//   bit A-2            RD   (1 read, 0 write)
//   bits A-3 -: IDW    master ID
//   low bits           memory address
package ufib_pkg;

    localparam int REQ_FROM_MSB = 0;
    localparam int RD_FROM_MSB  = 1;
    localparam int ID_FROM_MSB  = 2;

    function automatic int req_bit(input int a);
        return a - 1 - REQ_FROM_MSB;
    endfunction

    function automatic int rd_bit(input int a);
        return a - 1 - RD_FROM_MSB;
    endfunction

    function automatic int id_msb(input int a);
        return a - 1 - ID_FROM_MSB;
    endfunction

endpackage

// File: rtl/ufib_arbiter.sv
// rtl/ufib_arbiter.sv - request arbiter, one-hot grant plus winner index
//
// Policy macro: UFIB_ROUND_ROBIN_EN
//   defined   : round-robin, search starts after the last winner (pointer register)
//   undefined : fixed priority, lowest index wins (purely combinational)
// Ports:
//   clk, rst, advance  (round-robin build only) clock, sync active-high reset,
//                      pointer update strobe (a grant was taken this cycle)
//   req      [N-1:0]   request vector
//   gnt      [N-1:0]   one-hot grant
//   gnt_idx  [IW-1:0]  index of the granted master
//   gnt_vld            any request granted
module ufib_arbiter #(
    parameter int N  = 1,
    parameter int IW = 1
) (
`ifdef UFIB_ROUND_ROBIN_EN
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
`endif
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

`ifdef UFIB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        ptr_d = ptr_q;
        if (advance && gnt_vld) begin
            ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        // Walk downward so the lowest requesting index is the last to overwrite.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
                gnt_vld = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/ufi_bus_fabric.sv
// rtl/ufi_bus_fabric.sv - UFI interconnect: N masters arbitrated onto one slave, read return broadcast
//
// Policy macro: UFIB_ROUND_ROBIN_EN (round-robin when defined, fixed priority otherwise)
// Ports:
//   iCLK, iRST           clock, synchronous active-high reset
//   iMUfiWd/iMUfiAdrs    packed master write data / command words (master x at slice x)
//   oMUfiRdy             per-master one-cycle accept pulse
//   oSUfiWd/oSUfiAdrs    registered request to slave
//   iSUfiRdy             slave can accept a request this cycle
//   iSUfiRd/iSUfiAdrs    slave read-return data / command echo
//   oMUfiRd/oMUfiAdrs    registered read return broadcast to all masters
module ufi_bus_fabric
    import ufib_pkg::*;
#(
    parameter int pBlockConnectNum = 1,
    parameter int pBlockAdrsWidth  = 1,
    parameter int pUfiDqBusWidth   = 16,
    parameter int pUfiAdrsBusWidth = 32
) (
    input  logic                                       iCLK,
    input  logic                                       iRST,
    input  logic [pBlockConnectNum*pUfiDqBusWidth-1:0]   iMUfiWd,
    input  logic [pBlockConnectNum*pUfiAdrsBusWidth-1:0] iMUfiAdrs,
    output logic [pBlockConnectNum-1:0]                oMUfiRdy,
    output logic [pUfiDqBusWidth-1:0]                  oSUfiWd,
    output logic [pUfiAdrsBusWidth-1:0]                oSUfiAdrs,
    input  logic                                       iSUfiRdy,
    input  logic [pUfiDqBusWidth-1:0]                  iSUfiRd,
    input  logic [pUfiAdrsBusWidth-1:0]                iSUfiAdrs,
    output logic [pUfiDqBusWidth-1:0]                  oMUfiRd,
    output logic [pUfiAdrsBusWidth-1:0]                oMUfiAdrs
);

    localparam int N      = pBlockConnectNum;
    localparam int IW     = pBlockAdrsWidth;
    localparam int D      = pUfiDqBusWidth;
    localparam int A      = pUfiAdrsBusWidth;
    localparam int REQ_B  = req_bit(A);
    localparam int ID_MSB = id_msb(A);

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          take;
    logic [A-1:0]  win_adrs;
    logic [D-1:0]  win_wd;

    logic [A-1:0]  s_adrs_q,  s_adrs_d;
    logic [D-1:0]  s_wd_q,    s_wd_d;
    logic [N-1:0]  m_rdy_q,   m_rdy_d;
    logic [D-1:0]  m_rd_q,    m_rd_d;
    logic [A-1:0]  m_radrs_q, m_radrs_d;

    always_comb begin
        req = '0;
        for (int x = 0; x < N; x++) begin
            req[x] = iMUfiAdrs[x*A + REQ_B];
        end
    end

    assign take = iSUfiRdy & gnt_vld;

    ufib_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arbiter (
`ifdef UFIB_ROUND_ROBIN_EN
        .clk     (iCLK),
        .rst     (iRST),
        .advance (take),
`endif
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // AND-OR mux on the one-hot grant keeps the select free of out-of-range indices.
    always_comb begin
        win_adrs = '0;
        win_wd   = '0;
        for (int x = 0; x < N; x++) begin
            if (gnt[x]) begin
                win_adrs = win_adrs | iMUfiAdrs[x*A +: A];
                win_wd   = win_wd   | iMUfiWd[x*D +: D];
            end
        end
    end

    always_comb begin
        // Idle: drop REQ but keep the rest of the last request on the bus.
        s_adrs_d        = s_adrs_q;
        s_adrs_d[REQ_B] = 1'b0;
        s_wd_d          = s_wd_q;
        m_rdy_d         = '0;
        if (take) begin
            s_adrs_d                 = win_adrs;
            s_adrs_d[ID_MSB -: IW]   = gnt_idx;
            s_wd_d                   = win_wd;
            m_rdy_d                  = gnt;
        end
        m_rd_d    = iSUfiRd;
        m_radrs_d = iSUfiAdrs;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s_adrs_q  <= '0;
            s_wd_q    <= '0;
            m_rdy_q   <= '0;
            m_rd_q    <= '0;
            m_radrs_q <= '0;
        end else begin
            s_adrs_q  <= s_adrs_d;
            s_wd_q    <= s_wd_d;
            m_rdy_q   <= m_rdy_d;
            m_rd_q    <= m_rd_d;
            m_radrs_q <= m_radrs_d;
        end
    end

    assign oSUfiAdrs = s_adrs_q;
    assign oSUfiWd   = s_wd_q;
    assign oMUfiRdy  = m_rdy_q;
    assign oMUfiRd   = m_rd_q;
    assign oMUfiAdrs = m_radrs_q;

endmodule

// File: tb/tb_ufi_bus_fabric.sv
// tb/tb_ufi_bus_fabric.sv - scoreboard bench for ufi_bus_fabric (N=2)
module tb_ufi_bus_fabric;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int D  = 16;
    localparam int A  = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*D-1:0] m_wd;
    logic [N*A-1:0] m_adrs;
    logic [N-1:0]   m_rdy;
    logic [D-1:0]   s_wd;
    logic [A-1:0]   s_adrs;
    logic           s_rdy;
    logic [D-1:0]   s_rd;
    logic [A-1:0]   s_radrs;
    logic [D-1:0]   m_rd;
    logic [A-1:0]   m_radrs;

    always #5 clk = ~clk;

    ufi_bus_fabric #(
        .pBlockConnectNum (N),
        .pBlockAdrsWidth  (IW),
        .pUfiDqBusWidth   (D),
        .pUfiAdrsBusWidth (A)
    ) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iMUfiWd   (m_wd),
        .iMUfiAdrs (m_adrs),
        .oMUfiRdy  (m_rdy),
        .oSUfiWd   (s_wd),
        .oSUfiAdrs (s_adrs),
        .iSUfiRdy  (s_rdy),
        .iSUfiRd   (s_rd),
        .iSUfiAdrs (s_radrs),
        .oMUfiRd   (m_rd),
        .oMUfiAdrs (m_radrs)
    );

    typedef struct packed {
        logic [A-1:0] adrs;
        logic [D-1:0] wd;
    } word_t;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
        logic [A-1:0]  adrs;
        logic [D-1:0]  wd;
    } gexp_t;

    typedef struct packed {
        logic [A-1:0] adrs;
        logic [D-1:0] rd;
    } rexp_t;

    word_t        mq [N][$];
    rexp_t        rq [$];
    int           grant_log [$];
    logic [D-1:0] mem [logic [15:0]];

    int           npass = 0;
    int           ntot  = 0;
    int           rr_ptr = 0;
    logic [A-1:0] last_adrs = '0;
    logic [D-1:0] last_wd   = '0;
    logic         ret_drv   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive_masters();
        for (int x = 0; x < N; x++) begin
            if (mq[x].size() > 0) begin
                m_adrs[x*A +: A] = mq[x][0].adrs;
                m_wd[x*D +: D]   = mq[x][0].wd;
            end else begin
                m_adrs[x*A +: A] = '0;
                m_wd[x*D +: D]   = '0;
            end
        end
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        drive_masters();
        repeat (ncyc) @(posedge clk);
        #1;
        chk("rst_rdy",     64'(m_rdy),   64'd0);
        chk("rst_s_adrs",  64'(s_adrs),  64'd0);
        chk("rst_s_wd",    64'(s_wd),    64'd0);
        chk("rst_m_rd",    64'(m_rd),    64'd0);
        chk("rst_m_radrs", 64'(m_radrs), 64'd0);
        rst       = 1'b0;
        rr_ptr    = 0;
        last_adrs = '0;
        last_wd   = '0;
        ret_drv   = 1'b0;
        s_rd      = '0;
        s_radrs   = '0;
    endtask

    // One clock: predict the grant, advance the edge, check slave and return
    // ports against the prediction, then let the slave model respond.
    task automatic cycle();
        gexp_t    e;
        int       w;
        logic [N-1:0] reqv;
        rexp_t    r;
        drive_masters();
        e = '0;
        w = -1;
        for (int x = 0; x < N; x++) begin
            reqv[x] = (mq[x].size() > 0) && mq[x][0].adrs[A-1];
        end
        if (s_rdy && (|reqv)) begin
`ifdef UFIB_ROUND_ROBIN_EN
            for (int i = 0; i < N; i++) begin
                int j;
                j = (rr_ptr + i) % N;
                if (w < 0 && reqv[j]) w = j;
            end
            rr_ptr = (w + 1) % N;
`else
            for (int i = N - 1; i >= 0; i--) begin
                if (reqv[i]) w = i;
            end
`endif
        end
        if (w >= 0) begin
            e.vld                = 1'b1;
            e.idx                = w[IW-1:0];
            e.adrs               = mq[w][0].adrs;
            e.adrs[A-3 -: IW]    = w[IW-1:0];
            e.wd                 = mq[w][0].wd;
            last_adrs            = e.adrs;
            last_wd              = e.wd;
        end else begin
            e.adrs        = last_adrs;
            e.adrs[A-1]   = 1'b0;
            e.wd          = last_wd;
        end

        @(posedge clk);
        #1;
        if (w >= 0) begin
            void'(mq[w].pop_front());
            grant_log.push_back(w);
        end

        if (ret_drv) begin
            if (rq.size() == 0) begin
                chk("ret_unexpected", 64'd1, 64'd0);
            end else begin
                r = rq.pop_front();
                chk("ret_adrs", 64'(m_radrs), 64'(r.adrs));
                chk("ret_data", 64'(m_rd),    64'(r.rd));
            end
        end else begin
            chk("ret_idle", 64'(m_radrs[A-1]), 64'd0);
        end

        chk("grant_rdy", 64'(m_rdy),  e.vld ? (64'd1 << e.idx) : 64'd0);
        chk("slv_adrs",  64'(s_adrs), 64'(e.adrs));
        chk("slv_wd",    64'(s_wd),   64'(e.wd));

        ret_drv = 1'b0;
        s_radrs = '0;
        s_rd    = '0;
        if (s_adrs[A-1]) begin
            if (s_adrs[A-2]) begin
                s_radrs = s_adrs;
                s_rd    = mem.exists(s_adrs[15:0]) ? mem[s_adrs[15:0]] : '0;
                ret_drv = 1'b1;
            end else begin
                mem[s_adrs[15:0]] = s_wd;
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int k;
        k = 0;
        while ((mq[0].size() > 0 || mq[1].size() > 0) && k < max_cyc) begin
            cycle();
            k++;
        end
        chk("drain_done", 64'(mq[0].size() + mq[1].size()), 64'd0);
        repeat (2) cycle();
    endtask

    initial begin
        int exp_fixed [8];
        int exp_rr    [8];
        exp_fixed = '{0, 0, 0, 0, 1, 1, 1, 1};
        exp_rr    = '{0, 1, 0, 1, 0, 1, 0, 1};

        rst     = 1'b1;
        s_rdy   = 1'b0;
        s_rd    = '0;
        s_radrs = '0;
        m_wd    = '0;
        m_adrs  = '0;

        do_reset(5);

        // Single write from master 0.
        s_rdy = 1'b1;
        mq[0].push_back('{adrs: 32'h8000_0005, wd: 16'h0005});
        cycle();
        chk("wr_literal_adrs", 64'(s_adrs), 64'h8000_0005);
        chk("wr_literal_rdy",  64'(m_rdy),  64'd1);
        cycle();
        chk("wr_rdy_one_cycle", 64'(m_rdy), 64'd0);

        // Read with return.
        mem[16'h0010] = 16'h1234;
        mq[0].push_back('{adrs: 32'hC000_0010, wd: 16'h0000});
        rq.push_back('{adrs: 32'hC000_0010, rd: 16'h1234});
        cycle();
        chk("rd_literal_adrs", 64'(s_adrs), 64'hC000_0010);
        cycle();
        chk("rd_literal_data", 64'(m_rd), 64'h1234);
        cycle();

        // Backpressure for three cycles, then grant.
        s_rdy = 1'b0;
        mq[0].push_back('{adrs: 32'h8000_0020, wd: 16'hBEEF});
        repeat (3) cycle();
        s_rdy = 1'b1;
        cycle();
        chk("bp_grant_rdy", 64'(m_rdy), 64'd1);
        cycle();

        // Contention between two continuously requesting masters.
        do_reset(2);
        grant_log.delete();
        for (int k = 0; k < 4; k++) begin
            mq[0].push_back('{adrs: 32'h8000_0100 + 32'(k), wd: 16'hA000 + 16'(k)});
            mq[1].push_back('{adrs: 32'h8000_0200 + 32'(k), wd: 16'hB000 + 16'(k)});
        end
        drain(20);
        chk("cont_grants", 64'(grant_log.size()), 64'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
`ifdef UFIB_ROUND_ROBIN_EN
            chk("cont_order", 64'(grant_log[k]), 64'(exp_rr[k]));
`else
            chk("cont_order", 64'(grant_log[k]), 64'(exp_fixed[k]));
`endif
        end

        // Reset in the middle of traffic.
        for (int k = 0; k < 3; k++) begin
            mq[0].push_back('{adrs: 32'h8000_0300 + 32'(k), wd: 16'hC000 + 16'(k)});
            mq[1].push_back('{adrs: 32'h8000_0400 + 32'(k), wd: 16'hD000 + 16'(k)});
        end
        cycle();
        do_reset(1);
        drain(20);

        // Burst: 256 writes then 256 reads back.
        for (int i = 0; i < 256; i++) begin
            mq[0].push_back('{adrs: 32'h8000_0000 | 32'(i), wd: 16'(i)});
        end
        drain(300);
        for (int i = 0; i < 256; i++) begin
            mq[0].push_back('{adrs: 32'hC000_0000 | 32'(i), wd: 16'h0000});
            rq.push_back('{adrs: 32'hC000_0000 | 32'(i), rd: 16'(i)});
        end
        drain(300);
        chk("burst_returns_left", 64'(rq.size()), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
